// File: rtl/song_player.sv
// song_player: auto-play sequencer feeding the keyboard tone generator.
// Walks a synchronous song ROM, holding each note for dur units plus a gap.
module song_player #(
  parameter int TICKS_PER_UNIT = 6_250_000,
  parameter int GAP_TICKS      = 500_000,
  parameter int SONG_NUM       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       btn_prev,
  input  logic       btn_pause,
  input  logic       btn_next,
  output logic [7:0] rom_addr,
  input  logic [8:0] rom_data,
  output logic [6:0] key,
  output logic [1:0] pitch,
  output logic [1:0] song_idx,
  output logic [5:0] note_idx,
  output logic       playing,
  output logic       paused,
  output logic       song_done
);

  localparam int TW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TICKS_PER_UNIT - 1);
  localparam logic [GW-1:0] GLAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [1:0] SLAST = 2'(SONG_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_PAUSE
  } state_t;

  state_t state, saved;
  logic [TW-1:0] tick;
  logic [GW-1:0] gcnt;
  logic [3:0] units;
  logic [2:0] note_q;

  logic [1:0] song_inc, song_dec;
  logic [3:0] dur;
  logic play_end, gap_end, last_note;

  function automatic logic [6:0] onehot(input logic [2:0] n);
    onehot = (n == 3'd0) ? 7'd0 : 7'd1 << (n - 3'd1);
  endfunction

  assign song_inc  = (song_idx == SLAST) ? 2'd0 : song_idx + 2'd1;
  assign song_dec  = (song_idx == 2'd0) ? SLAST : song_idx - 2'd1;
  assign dur       = rom_data[3:0];
  assign play_end  = (tick == TLAST) && (units == 4'd1);
  assign gap_end   = (gcnt == GLAST);
  assign last_note = (note_idx == 6'd63);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      saved     <= S_IDLE;
      key       <= 7'd0;
      pitch     <= 2'd0;
      song_idx  <= 2'd0;
      note_idx  <= 6'd0;
      rom_addr  <= 8'd0;
      playing   <= 1'b0;
      paused    <= 1'b0;
      song_done <= 1'b0;
      tick      <= '0;
      gcnt      <= '0;
      units     <= 4'd0;
      note_q    <= 3'd0;
    end else begin
      song_done <= 1'b0;
      if (!en) begin
        state    <= S_IDLE;
        key      <= 7'd0;
        playing  <= 1'b0;
        paused   <= 1'b0;
        note_idx <= 6'd0;
        if (btn_next)
          song_idx <= song_inc;
        else if (btn_prev)
          song_idx <= song_dec;
      end else if (btn_next || btn_prev) begin
        // song change overrides everything; an end marker still reports
        song_idx <= btn_next ? song_inc : song_dec;
        note_idx <= 6'd0;
        key      <= 7'd0;
        playing  <= 1'b0;
        paused   <= 1'b0;
        state    <= S_FETCH;
        if (state == S_LOAD && dur == 4'd0)
          song_done <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: state <= S_FETCH;
          S_FETCH: begin
            rom_addr <= {song_idx, note_idx};
            state    <= S_LOAD;
          end
          S_LOAD: begin
            if (dur == 4'd0) begin
              song_done <= 1'b1;
              song_idx  <= song_inc;
              note_idx  <= 6'd0;
              state     <= S_FETCH;
            end else begin
              note_q  <= rom_data[6:4];
              pitch   <= rom_data[8:7];
              key     <= onehot(rom_data[6:4]);
              units   <= dur;
              tick    <= '0;
              gcnt    <= '0;
              playing <= 1'b1;
              state   <= S_PLAY;
            end
          end
          S_PLAY: begin
            // the cycle a pause lands in still counts as played
            if (tick == TLAST) begin
              tick  <= '0;
              units <= units - 4'd1;
            end else begin
              tick <= tick + TW'(1);
            end
            if (play_end) begin
              key <= 7'd0;
              if (GAP_TICKS == 0) begin
                playing <= 1'b0;
                state   <= S_FETCH;
                if (last_note) begin
                  song_done <= 1'b1;
                  song_idx  <= song_inc;
                  note_idx  <= 6'd0;
                end else begin
                  note_idx <= note_idx + 6'd1;
                end
              end else if (btn_pause) begin
                saved  <= S_GAP;
                paused <= 1'b1;
                state  <= S_PAUSE;
              end else begin
                state <= S_GAP;
              end
            end else if (btn_pause) begin
              saved  <= S_PLAY;
              key    <= 7'd0;
              paused <= 1'b1;
              state  <= S_PAUSE;
            end
          end
          S_GAP: begin
            if (gap_end) begin
              playing <= 1'b0;
              state   <= S_FETCH;
              if (last_note) begin
                song_done <= 1'b1;
                song_idx  <= song_inc;
                note_idx  <= 6'd0;
              end else begin
                note_idx <= note_idx + 6'd1;
              end
            end else begin
              gcnt <= gcnt + GW'(1);
              if (btn_pause) begin
                saved  <= S_GAP;
                paused <= 1'b1;
                state  <= S_PAUSE;
              end
            end
          end
          S_PAUSE: begin
            if (btn_pause) begin
              state  <= saved;
              paused <= 1'b0;
              if (saved == S_PLAY)
                key <= onehot(note_q);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_player.sv
// tb_song_player: directed vectors and playback sequences for song_player.
// Small timing parameters keep every sequence a few hundred cycles long.
module tb_song_player;

  logic       clk = 1'b0;
  logic       rst, en, btn_prev, btn_pause, btn_next;
  logic [7:0] rom_addr;
  logic [8:0] rom_data;
  logic [6:0] key;
  logic [1:0] pitch, song_idx;
  logic [5:0] note_idx;
  logic       playing, paused, song_done;

  logic [8:0] rom [256];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  song_player #(
    .TICKS_PER_UNIT(4),
    .GAP_TICKS(2),
    .SONG_NUM(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .btn_prev(btn_prev), .btn_pause(btn_pause), .btn_next(btn_next),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .key(key), .pitch(pitch), .song_idx(song_idx), .note_idx(note_idx),
    .playing(playing), .paused(paused), .song_done(song_done)
  );

  typedef struct {
    logic       en, nx, pv, pz;
    logic [6:0] key;
    logic [1:0] pitch, song;
    logic [5:0] note;
    logic [7:0] addr;
    logic       pl, pa, dn;
  } vec_t;

  vec_t vq[$];
  int errs = 0;
  int checks = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step(logic e, logic nx, logic pv, logic pz);
    en        = e;
    btn_next  = nx;
    btn_prev  = pv;
    btn_pause = pz;
    @(negedge clk);
  endtask

  task automatic add(int n, logic [6:0] k, logic [1:0] p, logic [1:0] s,
                     logic [5:0] nt, logic [7:0] a, logic pl, logic dn);
    vec_t v;
    v.en = 1'b1; v.nx = 1'b0; v.pv = 1'b0; v.pz = 1'b0;
    v.key = k; v.pitch = p; v.song = s; v.note = nt; v.addr = a;
    v.pl = pl; v.pa = 1'b0; v.dn = dn;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  function automatic logic [27:0] outv();
    return {key, pitch, song_idx, note_idx, rom_addr, playing, paused, song_done};
  endfunction

  initial begin
    int cnt, hit, maxn;
    for (int i = 0; i < 256; i++) rom[i] = 9'd0;
    rom[0]     = {2'd1, 3'd3, 4'd2};
    rom[1]     = {2'd2, 3'd0, 4'd1};
    rom[8'h40] = {2'd0, 3'd5, 4'd1};
    for (int i = 0; i < 64; i++) rom[128 + i] = {2'd3, 3'(i % 7 + 1), 4'd1};

    rst = 1'b1; en = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; btn_pause = 1'b0;
    @(negedge clk);
    chk("reset_state", {4'd0, outv()}, 32'd0);
    rst = 1'b0;

    // song0: note3 dur2 pitch1, rest dur1 pitch2, end marker
    add(2, 7'h00, 2'd0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b0);
    add(8, 7'h04, 2'd1, 2'd0, 6'd0, 8'h00, 1'b1, 1'b0);
    add(2, 7'h00, 2'd1, 2'd0, 6'd0, 8'h00, 1'b1, 1'b0);
    add(1, 7'h00, 2'd1, 2'd0, 6'd1, 8'h00, 1'b0, 1'b0);
    add(1, 7'h00, 2'd1, 2'd0, 6'd1, 8'h01, 1'b0, 1'b0);
    add(6, 7'h00, 2'd2, 2'd0, 6'd1, 8'h01, 1'b1, 1'b0);
    add(1, 7'h00, 2'd2, 2'd0, 6'd2, 8'h01, 1'b0, 1'b0);
    add(1, 7'h00, 2'd2, 2'd0, 6'd2, 8'h02, 1'b0, 1'b0);
    add(1, 7'h00, 2'd2, 2'd1, 6'd0, 8'h02, 1'b0, 1'b1);
    add(1, 7'h00, 2'd2, 2'd1, 6'd0, 8'h40, 1'b0, 1'b0);
    add(1, 7'h10, 2'd0, 2'd1, 6'd0, 8'h40, 1'b1, 1'b0);
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].en, vq[i].nx, vq[i].pv, vq[i].pz);
      chk($sformatf("vec%0d", i), {4'd0, outv()},
          {4'd0, vq[i].key, vq[i].pitch, vq[i].song, vq[i].note,
           vq[i].addr, vq[i].pl, vq[i].pa, vq[i].dn});
    end

    // prev / next wrap
    step(1, 0, 1, 0);
    chk("prev1_song", {key, song_idx, playing}, {7'h00, 2'd0, 1'b0});
    step(1, 0, 1, 0);
    chk("prev_wrap_song", {song_idx, note_idx}, {2'd2, 6'd0});
    step(1, 0, 0, 0);
    chk("prev_wrap_addr", rom_addr, 8'h80);
    step(1, 1, 0, 0);
    chk("next1_song", song_idx, 2'd0);
    step(1, 1, 0, 0);
    chk("next2_song", song_idx, 2'd1);

    // pause 3 cycles into song0 note0, hold 20 cycles, resume
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("pre_pause_key", {key, pitch}, {7'h04, 2'd1});
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("pause_enter", {key, paused, playing}, {7'h00, 1'b1, 1'b1});
    cnt = 0;
    for (int i = 0; i < 19; i++) begin
      step(1, 0, 0, 0);
      if (paused && key == 7'h00) cnt++;
    end
    chk("pause_hold", cnt, 19);
    step(1, 0, 0, 1);
    chk("resume_key", {key, paused}, {7'h04, 1'b0});
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      if (key == 7'h04) cnt++;
    end
    chk("resume_remaining", cnt, 4);
    step(1, 0, 0, 0);
    chk("resume_gap", {key, playing, paused}, {7'h00, 1'b1, 1'b0});
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("resume_next_note", {playing, note_idx}, {1'b0, 6'd1});

    // next and pause together during PLAY
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("song1_key", key, 7'h10);
    step(1, 1, 0, 1);
    chk("next_over_pause", {key, song_idx, note_idx, paused, playing},
        {7'h00, 2'd2, 6'd0, 1'b0, 1'b0});

    // reset mid-PLAY
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("song2_key", {key, pitch, song_idx}, {7'h01, 2'd3, 2'd2});
    rst = 1'b1;
    step(1, 0, 0, 0);
    chk("mid_reset", {key, song_idx, note_idx, playing, rom_addr},
        {7'h00, 2'd0, 6'd0, 1'b0, 8'h00});
    rst = 1'b0;

    // en drop mid-note keeps song, en rise restarts at entry 0
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("en_pre_drop", {key, song_idx}, {7'h10, 2'd1});
    step(0, 0, 0, 0);
    chk("en_drop", {key, playing, paused, song_idx, note_idx},
        {7'h00, 1'b0, 1'b0, 2'd1, 6'd0});
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("en_restart_addr", rom_addr, 8'h40);

    // 64-entry song wraps after its last gap
    step(1, 1, 0, 0);
    hit = 0; maxn = 0;
    for (int k = 1; k <= 600 && hit == 0; k++) begin
      step(1, 0, 0, 0);
      if (int'(note_idx) > maxn) maxn = int'(note_idx);
      if (song_done) hit = k;
    end
    chk("wrap_cycles", hit, 512);
    chk("wrap_max_note", maxn, 63);
    chk("wrap_state", {song_idx, note_idx, playing}, {2'd0, 6'd0, 1'b0});
    step(1, 0, 0, 0);
    chk("wrap_done_pulse", {song_done, rom_addr}, {1'b0, 8'h00});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
